// File: rtl/glitch_reset_seq.sv
// Target reset sequencer: holds rst_o for a programmed time, waits a settle time, then pulses done.
// Optional GLITCH_RESET_ABORT_EN adds an abort input that cancels a running sequence.
module glitch_reset_seq #(
    parameter int CNT_W          = 16,
    parameter int OUT_ACTIVE_LOW = 1,
    parameter int MIN_HOLD       = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0] settle_cycles,
`ifdef GLITCH_RESET_ABORT_EN
    input  logic             abort,
`endif
    output logic             rst_o,
    output logic             busy,
    output logic             done
);

    localparam logic RST_ON  = (OUT_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic RST_OFF = ~RST_ON;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] settle_q;
    logic             armed;
    logic             accept;
    logic             abort_req;

    function automatic logic [CNT_W-1:0] clamp_hold(input logic [CNT_W-1:0] h);
        if (h < CNT_W'(MIN_HOLD))
            return CNT_W'(MIN_HOLD);
        return h;
    endfunction

`ifdef GLITCH_RESET_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept = (state == IDLE) && en && armed;

    // Configuration is captured once per sequence so later input changes are ignored
    always_ff @(posedge clk_in) begin
        if (accept) begin
            hold_q   <= clamp_hold(hold_cycles);
            settle_q <= settle_cycles;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
            rst_o <= RST_OFF;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rst_o <= RST_OFF;
                    busy  <= 1'b0;
                    if (!en) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed <= 1'b0;
                        cnt   <= '0;
                        state <= HOLD;
                        rst_o <= RST_ON;
                        busy  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (abort_req) begin
                        state <= IDLE;
                        cnt   <= '0;
                        armed <= 1'b0;
                        rst_o <= RST_OFF;
                        busy  <= 1'b0;
                    end else if (cnt == hold_q - CNT_W'(1)) begin
                        cnt   <= '0;
                        rst_o <= RST_OFF;
                        if (settle_q != '0) begin
                            state <= SETTLE;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (abort_req) begin
                        state <= IDLE;
                        cnt   <= '0;
                        armed <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt == settle_q - CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_reset_seq.sv
// Directed bench for glitch_reset_seq: active-low and active-high instances share all stimulus.
module tb_glitch_reset_seq;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] hold_cycles = 16'd0;
    logic [15:0] settle_cycles = 16'd0;
    logic        abort = 1'b0;
    logic        rst_o_a, busy_a, done_a;
    logic        rst_o_b, busy_b, done_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk_in = ~clk_in;

    glitch_reset_seq #(.CNT_W(16), .OUT_ACTIVE_LOW(1), .MIN_HOLD(1)) dut_a (
        .clk_in(clk_in), .rst(rst), .en(en),
        .hold_cycles(hold_cycles), .settle_cycles(settle_cycles),
`ifdef GLITCH_RESET_ABORT_EN
        .abort(abort),
`endif
        .rst_o(rst_o_a), .busy(busy_a), .done(done_a)
    );

    glitch_reset_seq #(.CNT_W(16), .OUT_ACTIVE_LOW(0), .MIN_HOLD(1)) dut_b (
        .clk_in(clk_in), .rst(rst), .en(en),
        .hold_cycles(hold_cycles), .settle_cycles(settle_cycles),
`ifdef GLITCH_RESET_ABORT_EN
        .abort(abort),
`endif
        .rst_o(rst_o_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Arms with one en-low cycle, then accepts; returns sampling cycle 1 after accept
    task automatic start(input logic [15:0] h, input logic [15:0] s);
        en = 1'b0;
        tick();
        hold_cycles = h;
        settle_cycles = s;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic measure(input int max_c, input int chg_c, input logic [15:0] chg_v,
                           output int a_cnt, output int a_first, output int a_last,
                           output int b_cnt, output int d_cnt, output int d_first,
                           output int busy_cnt);
        a_cnt = 0; a_first = 0; a_last = 0; b_cnt = 0; d_cnt = 0; d_first = 0; busy_cnt = 0;
        for (int c = 1; c <= max_c; c++) begin
            if (rst_o_a === 1'b0) begin
                a_cnt++;
                if (a_first == 0) a_first = c;
                a_last = c;
            end
            if (rst_o_b === 1'b1) b_cnt++;
            if (done_a === 1'b1) begin
                d_cnt++;
                if (d_first == 0) d_first = c;
            end
            if (busy_a === 1'b1) busy_cnt++;
            if (c == chg_c) hold_cycles = chg_v;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        tick();
        tick();
        total_cnt++; if (rst_o_a !== 1'b1) $display("FAIL reset_rst_o_a: got %b expected 1", rst_o_a); else pass_cnt++;
        total_cnt++; if (rst_o_b !== 1'b0) $display("FAIL reset_rst_o_b: got %b expected 0", rst_o_b); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else pass_cnt++;
        total_cnt++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_a); else pass_cnt++;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL unarmed_busy: got %b expected 0", busy_a); else pass_cnt++;
        total_cnt++; if (rst_o_a !== 1'b1) $display("FAIL unarmed_rst_o: got %b expected 1", rst_o_a); else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_hold32();
        int ac, af, al, bc, dc, df, bu;
        start(16'd32, 16'd0);
        measure(40, 0, 16'd0, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (ac !== 32) $display("FAIL h32_len: got %0d expected 32", ac); else pass_cnt++;
        total_cnt++; if (af !== 1) $display("FAIL h32_first: got %0d expected 1", af); else pass_cnt++;
        total_cnt++; if (al !== 32) $display("FAIL h32_last: got %0d expected 32", al); else pass_cnt++;
        total_cnt++; if (df !== 33) $display("FAIL h32_done_at: got %0d expected 33", df); else pass_cnt++;
        total_cnt++; if (dc !== 1) $display("FAIL h32_done_cnt: got %0d expected 1", dc); else pass_cnt++;
        total_cnt++; if (bu !== 33) $display("FAIL h32_busy: got %0d expected 33", bu); else pass_cnt++;
        total_cnt++; if (bc !== 32) $display("FAIL h32_len_b: got %0d expected 32", bc); else pass_cnt++;
    endtask

    task automatic test_hold_settle();
        int ac, af, al, bc, dc, df, bu;
        start(16'd5, 16'd10);
        measure(25, 3, 16'd2, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (ac !== 5) $display("FAIL hs_len: got %0d expected 5", ac); else pass_cnt++;
        total_cnt++; if (al !== 5) $display("FAIL hs_last: got %0d expected 5", al); else pass_cnt++;
        total_cnt++; if (df !== 16) $display("FAIL hs_done_at: got %0d expected 16", df); else pass_cnt++;
        total_cnt++; if (dc !== 1) $display("FAIL hs_done_cnt: got %0d expected 1", dc); else pass_cnt++;
        total_cnt++; if (bu !== 16) $display("FAIL hs_busy: got %0d expected 16", bu); else pass_cnt++;
    endtask

    task automatic test_min_hold();
        int ac, af, al, bc, dc, df, bu;
        start(16'd0, 16'd0);
        measure(6, 0, 16'd0, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (ac !== 1) $display("FAIL mh_len_a: got %0d expected 1", ac); else pass_cnt++;
        total_cnt++; if (bc !== 1) $display("FAIL mh_len_b: got %0d expected 1", bc); else pass_cnt++;
        total_cnt++; if (df !== 2) $display("FAIL mh_done_at: got %0d expected 2", df); else pass_cnt++;
        total_cnt++; if (bu !== 2) $display("FAIL mh_busy: got %0d expected 2", bu); else pass_cnt++;
        total_cnt++; if (rst_o_a !== 1'b1) $display("FAIL idle_level_a: got %b expected 1", rst_o_a); else pass_cnt++;
        total_cnt++; if (rst_o_b !== 1'b0) $display("FAIL idle_level_b: got %b expected 0", rst_o_b); else pass_cnt++;
    endtask

    task automatic test_en_held();
        int ac, af, al, bc, dc, df, bu;
        int asserted, dones;
        asserted = 0;
        dones = 0;
        en = 1'b0;
        tick();
        hold_cycles = 16'd4;
        settle_cycles = 16'd4;
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rst_o_a === 1'b0) asserted++;
            if (done_a === 1'b1) dones++;
        end
        total_cnt++; if (dones !== 1) $display("FAIL held_done_cnt: got %0d expected 1", dones); else pass_cnt++;
        total_cnt++; if (asserted !== 4) $display("FAIL held_assert_cnt: got %0d expected 4", asserted); else pass_cnt++;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        measure(12, 0, 16'd0, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (ac !== 4) $display("FAIL retrig_len: got %0d expected 4", ac); else pass_cnt++;
        total_cnt++; if (df !== 9) $display("FAIL retrig_done_at: got %0d expected 9", df); else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_rst_mid();
        int ac, af, al, bc, dc, df, bu;
        int asserted, dones;
        asserted = 0;
        dones = 0;
        en = 1'b0;
        tick();
        hold_cycles = 16'd10;
        settle_cycles = 16'd5;
        en = 1'b1;
        tick();
        tick();
        tick();
        total_cnt++; if (rst_o_a !== 1'b0) $display("FAIL rm_hold3: got %b expected 0", rst_o_a); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (rst_o_a !== 1'b1) $display("FAIL rm_release_a: got %b expected 1", rst_o_a); else pass_cnt++;
        total_cnt++; if (rst_o_b !== 1'b0) $display("FAIL rm_release_b: got %b expected 0", rst_o_b); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL rm_busy: got %b expected 0", busy_a); else pass_cnt++;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rst_o_a === 1'b0) asserted++;
            if (done_a === 1'b1) dones++;
            tick();
        end
        total_cnt++; if (dones !== 0) $display("FAIL rm_no_done: got %0d expected 0", dones); else pass_cnt++;
        total_cnt++; if (asserted !== 0) $display("FAIL rm_no_accept: got %0d expected 0", asserted); else pass_cnt++;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL rm_rearm_busy: got %b expected 1", busy_a); else pass_cnt++;
        en = 1'b0;
        measure(20, 0, 16'd0, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (df !== 16) $display("FAIL rm_rearm_done_at: got %0d expected 16", df); else pass_cnt++;
    endtask

`ifdef GLITCH_RESET_ABORT_EN
    task automatic test_abort();
        int ac, af, al, bc, dc, df, bu;
        start(16'd3, 16'd8);
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL ab_settle_busy: got %b expected 1", busy_a); else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL ab_busy: got %b expected 0", busy_a); else pass_cnt++;
        total_cnt++; if (rst_o_a !== 1'b1) $display("FAIL ab_rst_o: got %b expected 1", rst_o_a); else pass_cnt++;
        measure(20, 0, 16'd0, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (dc !== 0) $display("FAIL ab_no_done: got %0d expected 0", dc); else pass_cnt++;
        total_cnt++; if (bu !== 0) $display("FAIL ab_no_busy: got %0d expected 0", bu); else pass_cnt++;
        abort = 1'b1;
        tick();
        tick();
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL ab_idle_busy: got %b expected 0", busy_a); else pass_cnt++;
        abort = 1'b0;
        start(16'd2, 16'd0);
        measure(6, 0, 16'd0, ac, af, al, bc, dc, df, bu);
        total_cnt++; if (df !== 3) $display("FAIL ab_after_done_at: got %0d expected 3", df); else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hold32();
        test_hold_settle();
        test_min_hold();
        test_en_held();
        test_rst_mid();
`ifdef GLITCH_RESET_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
